// File: rtl/crc_frame_sequencer.sv
// Feeds byte frames bit-serially into an external crc_calc engine, appends CRC_WIDTH
// augmentation zeros and returns the engine remainder on a valid/ready result port.
module crc_frame_sequencer #(
    parameter int CRC_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CRC_WIDTH-1:0] cfg_init,
    input  logic [CRC_WIDTH-1:0] cfg_poly,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [CRC_WIDTH-1:0] m_crc,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_underrun,
    output logic                 eng_rst_n,
    output logic                 eng_data,
    output logic [CRC_WIDTH-1:0] eng_init,
    output logic [CRC_WIDTH-1:0] eng_poly,
    input  logic [CRC_WIDTH-1:0] eng_crc,
    output logic [2:0]           dbg_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_AUGMENT = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int AW = $clog2(CRC_WIDTH + 1);

    logic [2:0]           state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic                 last_q, last_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 hold_last_q, hold_last_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]        aug_cnt_q, aug_cnt_d;
    logic [CRC_WIDTH-1:0] init_q, init_d;
    logic [CRC_WIDTH-1:0] poly_q, poly_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic                 err_q, err_d;
    logic                 rdy;
    logic                 s_accept;
    logic                 cur_bit;

    // Both ports: a transfer happens at a rising clk edge where valid & ready are both high;
    // valid must not depend on ready, and ready never depends on valid.
    always_comb begin
        rdy = 1'b0;
        case (state_q)
            ST_IDLE:  rdy = 1'b1;
            ST_SHIFT: begin
                if (last_q)
                    rdy = 1'b0;
                else if (bit_cnt_q == 3'd7)
                    rdy = hold_valid_q & ~hold_last_q;  // hold drains this edge, refill allowed
                else
                    rdy = ~hold_valid_q;
            end
            default:  rdy = 1'b0;
        endcase
    end

    assign s_ready  = rst_n & rdy;
    assign s_accept = s_valid & s_ready;
    assign cur_bit  = LSB_FIRST ? shift_q[bit_cnt_q] : shift_q[3'd7 - bit_cnt_q];

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        last_d       = last_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        aug_cnt_d    = aug_cnt_q;
        init_d       = init_q;
        poly_d       = poly_q;
        crc_d        = crc_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_accept) begin
                    shift_d   = s_data;
                    last_d    = s_last;
                    init_d    = cfg_init;
                    poly_d    = cfg_poly;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (last_q) begin
                        aug_cnt_d = '0;
                        state_d   = ST_AUGMENT;
                    end else if (hold_valid_q) begin
                        shift_d      = hold_data_q;
                        last_d       = hold_last_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                // Placed after the drain so a same-edge refill keeps the hold buffer full.
                if (s_accept) begin
                    hold_data_d  = s_data;
                    hold_last_d  = s_last;
                    hold_valid_d = 1'b1;
                end
            end
            ST_AUGMENT: begin
                aug_cnt_d = aug_cnt_q + AW'(1);
                if (aug_cnt_q == AW'(CRC_WIDTH - 1))
                    state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                crc_d   = eng_crc;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (m_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'h00;
            last_q       <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= 3'd0;
            aug_cnt_q    <= '0;
            init_q       <= '0;
            poly_q       <= '0;
            crc_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            aug_cnt_q    <= aug_cnt_d;
            init_q       <= init_d;
            poly_q       <= poly_d;
            crc_q        <= crc_d;
            err_q        <= err_d;
        end
    end

    // Engine runs only while bits are being fed; held in reset otherwise so it never drifts.
    assign eng_rst_n    = rst_n & ((state_q == ST_SHIFT) | (state_q == ST_AUGMENT));
    assign eng_data     = rst_n & (state_q == ST_SHIFT) & cur_bit;
    assign eng_init     = init_q;
    assign eng_poly     = poly_q;
    assign m_crc        = crc_q;
    assign m_valid      = rst_n & (state_q == ST_DONE);
    assign err_underrun = err_q;
    assign dbg_state    = state_q;

endmodule
